// File: rtl/id_pkg.sv
// Shared constants, read-A select encodings, FSM states and immediate-extension helpers for id_stage_param.
// No timing of its own; the helpers are purely combinational.
// No flow control.
package id_pkg;

    localparam int OPC_W = 4;
    localparam int XW    = 64;

    localparam logic [1:0] RA_RS1  = 2'b00;
    localparam logic [1:0] RA_RD   = 2'b01;
    localparam logic [1:0] RA_LINK = 2'b10;
    localparam logic [1:0] RA_ZERO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DECODE = 2'b01,
        S_HOLD   = 2'b10
    } state_t;

    // Extend the low 'width' bits of value to XW bits; callers slice the width they need.
    function automatic logic [XW-1:0] sext(input logic [XW-1:0] value, input int width);
        logic [XW-1:0] r;
        for (int i = 0; i < XW; i++) begin
            r[i] = (i < width) ? value[i] : value[width-1];
        end
        return r;
    endfunction

    function automatic logic [XW-1:0] zext(input logic [XW-1:0] value, input int width);
        logic [XW-1:0] r;
        for (int i = 0; i < XW; i++) begin
            r[i] = (i < width) ? value[i] : 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// NREG x DW register file: two async read ports, one sync write port, R0 hardwired to zero.
// Read is combinational; a write lands on the clock edge. Optional macro ID_RF_BYPASS_EN forwards wr_data to matching reads.
// No flow control; writes are accepted every cycle.
module id_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [RW-1:0] rd_addr_a,
    input  logic [RW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b
);

    logic [DW-1:0] regs [NREG];
    logic          wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
`ifdef ID_RF_BYPASS_EN
        // wr_live already excludes R0, so R0 is never forwarded
        if (wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`endif
    end

endmodule

// File: rtl/id_stage_param.sv
// Parametrised instruction-decode stage: field extraction, register read, immediate extension, branch/jump targets.
// Latency: capture in IDLE, register bundle in DECODE, id_valid in HOLD; min issue interval 3 cycles. Macro ID_RF_BYPASS_EN enables write forwarding.
// Backpressure: bundle held stable in HOLD until ex_ready; enable_id while busy is dropped and flagged on drop_err.
module id_stage_param
    import id_pkg::*;
#(
    parameter int DW       = 16,
    parameter int NREG     = 8,
    parameter int RW       = $clog2(NREG),
    parameter int IMM_W    = 5,
    parameter int LINK_REG = NREG - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_id,
    input  logic [DW-1:0]    instruction,
    input  logic [DW-1:0]    nextPC,
    input  logic [1:0]       RAsrc,
    input  logic             RBsrc,
    input  logic             regDst,
    input  logic             ExtOp,
    input  logic             wr_en,
    input  logic [RW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [OPC_W-1:0] opcode,
    output logic             mode,
    output logic [DW-1:0]    BusA,
    output logic [DW-1:0]    BusB,
    output logic [DW-1:0]    Imm,
    output logic [DW-1:0]    BTarget,
    output logic [DW-1:0]    jumpTarget,
    output logic [RW-1:0]    dst_addr,
    output logic             busy,
    output logic             drop_err
);

    localparam logic [RW-1:0] LINK_IDX = RW'(LINK_REG);

    state_t        state_q, state_d;
    logic          load, decode;
    logic [DW-1:0] instr_q, npc_q;
    logic [RW-1:0] rd_f, rs1_f, rs2_f, ra_addr, rb_addr;
    logic [DW-1:0] ra_data, rb_data;
    logic [XW-1:0] imm_raw, joff_raw, imm_s, imm_z, joff_s;
    logic [DW-1:0] imm_ext, btgt, jtgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        decode  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_id) begin
                    load    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decode  = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (ex_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign id_valid = (state_q == S_HOLD);
    assign busy     = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              drop_err <= 1'b0;
        else if (enable_id && state_q != S_IDLE) drop_err <= 1'b1;
    end

    assign rd_f  = instr_q[DW-5 -: RW];
    assign rs1_f = instr_q[DW-5-RW -: RW];
    assign rs2_f = instr_q[DW-5-2*RW -: RW];

    always_comb begin
        case (RAsrc)
            RA_RS1:  ra_addr = rs1_f;
            RA_RD:   ra_addr = rd_f;
            RA_LINK: ra_addr = LINK_IDX;
            default: ra_addr = '0;
        endcase
        rb_addr = RBsrc ? rd_f : rs2_f;
    end

    id_regfile #(.DW(DW), .NREG(NREG), .RW(RW)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (ra_addr),
        .rd_addr_b (rb_addr),
        .rd_data_a (ra_data),
        .rd_data_b (rb_data)
    );

    // Branch offset is always signed; ExtOp only steers the Imm output.
    assign imm_raw  = XW'(instr_q[IMM_W-1:0]);
    assign joff_raw = XW'(instr_q[DW-5:0]);
    assign imm_s    = sext(imm_raw, IMM_W);
    assign imm_z    = zext(imm_raw, IMM_W);
    assign joff_s   = sext(joff_raw, DW - 4);
    assign imm_ext  = ExtOp ? imm_s[DW-1:0] : imm_z[DW-1:0];
    assign btgt     = npc_q + imm_s[DW-1:0];
    assign jtgt     = npc_q + joff_s[DW-1:0];

`ifdef ID_RF_BYPASS_EN
    logic [RW-1:0] src_a_q, src_b_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            npc_q      <= '0;
            opcode     <= '0;
            mode       <= 1'b0;
            BusA       <= '0;
            BusB       <= '0;
            Imm        <= '0;
            BTarget    <= '0;
            jumpTarget <= '0;
            dst_addr   <= '0;
`ifdef ID_RF_BYPASS_EN
            src_a_q    <= '0;
            src_b_q    <= '0;
`endif
        end else begin
            if (load) begin
                instr_q <= instruction;
                npc_q   <= nextPC;
            end
            if (decode) begin
                opcode     <= instr_q[DW-1 -: OPC_W];
                mode       <= instr_q[IMM_W];
                BusA       <= ra_data;
                BusB       <= rb_data;
                Imm        <= imm_ext;
                BTarget    <= btgt;
                jumpTarget <= jtgt;
                dst_addr   <= regDst ? LINK_IDX : rd_f;
`ifdef ID_RF_BYPASS_EN
                src_a_q    <= ra_addr;
                src_b_q    <= rb_addr;
`endif
            end
`ifdef ID_RF_BYPASS_EN
            // Keep the held operands coherent with later writes to their source registers.
            else if (state_q == S_HOLD && wr_en && wr_addr != '0) begin
                if (wr_addr == src_a_q) BusA <= wr_data;
                if (wr_addr == src_b_q) BusB <= wr_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_id_stage_param.sv
// Randomised plus directed bench for id_stage_param: driver pushes model predictions into a scoreboard,
// a negedge monitor pops and compares each bundle as EX accepts it.
module tb_id_stage_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_id;
    logic [15:0] instruction, nextPC;
    logic [1:0]  RAsrc;
    logic        RBsrc, regDst, ExtOp, wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        ex_ready;
    logic        id_valid;
    logic [3:0]  opcode;
    logic        mode;
    logic [15:0] BusA, BusB, Imm, BTarget, jumpTarget;
    logic [2:0]  dst_addr;
    logic        busy, drop_err;

    id_stage_param dut (
        .clk(clk), .rst_n(rst_n), .enable_id(enable_id), .instruction(instruction),
        .nextPC(nextPC), .RAsrc(RAsrc), .RBsrc(RBsrc), .regDst(regDst), .ExtOp(ExtOp),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ex_ready(ex_ready),
        .id_valid(id_valid), .opcode(opcode), .mode(mode), .BusA(BusA), .BusB(BusB),
        .Imm(Imm), .BTarget(BTarget), .jumpTarget(jumpTarget), .dst_addr(dst_addr),
        .busy(busy), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  opc;
        logic        mode;
        logic [15:0] busa, busb, imm, bt, jt;
        logic [2:0]  dst;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] model_rf [8];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decode rules with plain integer arithmetic on the model register array.
    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] npc,
                                   input logic [1:0] ras, input logic rbs,
                                   input logic rdst, input logic ext);
        exp_t e;
        int rd, rs1, rs2, ai, bi, imm5, simm, off12, soff, pc;
        rd    = int'(ins[11:9]);
        rs1   = int'(ins[8:6]);
        rs2   = int'(ins[5:3]);
        case (ras)
            2'd0:    ai = rs1;
            2'd1:    ai = rd;
            2'd2:    ai = 7;
            default: ai = 0;
        endcase
        bi    = rbs ? rd : rs2;
        imm5  = int'(ins[4:0]);
        simm  = (imm5 >= 16) ? imm5 - 32 : imm5;
        off12 = int'(ins[11:0]);
        soff  = (off12 >= 2048) ? off12 - 4096 : off12;
        pc    = int'(npc);
        e.opc  = ins[15:12];
        e.mode = ins[5];
        e.busa = (ai == 0) ? 16'h0 : model_rf[ai];
        e.busb = (bi == 0) ? 16'h0 : model_rf[bi];
        e.imm  = ext ? 16'(simm) : 16'(imm5);
        e.bt   = 16'(pc + simm);
        e.jt   = 16'(pc + soff);
        e.dst  = rdst ? 3'd7 : 3'(rd);
        return e;
    endfunction

    function automatic void mwrite(input logic [2:0] a, input logic [15:0] d);
        if (a != 3'd0) model_rf[a] = d;
    endfunction

    always @(negedge clk) begin
        if (rst_n && id_valid && ex_ready) begin
            if (sb_q.size() == 0) begin
                chk("mon_unexpected_bundle", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("mon_opcode", opcode, mon_e.opc);
                chk("mon_mode", mode, mon_e.mode);
                chk("mon_busa", BusA, mon_e.busa);
                chk("mon_busb", BusB, mon_e.busb);
                chk("mon_imm", Imm, mon_e.imm);
                chk("mon_btarget", BTarget, mon_e.bt);
                chk("mon_jumptarget", jumpTarget, mon_e.jt);
                chk("mon_dst_addr", dst_addr, mon_e.dst);
            end
        end
    end

    // All driver tasks start and end one time unit after a rising edge.
    task automatic rf_write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mwrite(a, d);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle_timeout", busy, 1'b0);
    endtask

    // Leaves the DUT in HOLD; optional write lands on the DECODE edge.
    task automatic issue_start(input logic [15:0] ins, input logic [15:0] npc,
                               input logic [1:0] ras, input logic rbs, input logic rdst,
                               input logic ext, input logic rdy, input logic dwr,
                               input logic [2:0] dwa, input logic [15:0] dwd);
        exp_t e;
        instruction = ins; nextPC = npc; RAsrc = ras; RBsrc = rbs; regDst = rdst;
        ExtOp = ext; ex_ready = rdy; enable_id = 1'b1;
        @(posedge clk); #1;
        enable_id = 1'b0;
        if (dwr) begin
            wr_en = 1'b1; wr_addr = dwa; wr_data = dwd;
        end
`ifdef ID_RF_BYPASS_EN
        if (dwr) mwrite(dwa, dwd);
        e = model(ins, npc, ras, rbs, rdst, ext);
`else
        e = model(ins, npc, ras, rbs, rdst, ext);
        if (dwr) mwrite(dwa, dwd);
`endif
        sb_q.push_back(e);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic finish_txn();
        ex_ready = 1'b1;
        wait_idle();
    endtask

    task automatic run(input logic [15:0] ins, input logic [15:0] npc, input logic [1:0] ras,
                       input logic rbs, input logic rdst, input logic ext);
        issue_start(ins, npc, ras, rbs, rdst, ext, 1'b1, 1'b0, 3'd0, 16'h0);
        finish_txn();
    endtask

    initial begin
        logic [15:0] w, hold_a;
        rst_n = 1'b0; enable_id = 1'b0; instruction = '0; nextPC = '0; RAsrc = '0;
        RBsrc = 1'b0; regDst = 1'b0; ExtOp = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; ex_ready = 1'b0;
        for (int k = 0; k < 8; k++) model_rf[k] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop_err", drop_err, 1'b0);
        chk("rst_busa", BusA, 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic decode
        rf_write(3'd5, 16'h1234);
        rf_write(3'd4, 16'h00FF);
        run(16'hD963, 16'h0004, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("dec_opcode", opcode, 4'hD);
        chk("dec_mode", mode, 1'b1);
        chk("dec_busa", BusA, 16'h1234);
        chk("dec_busb", BusB, 16'h00FF);
        chk("dec_imm", Imm, 16'h0003);
        chk("dec_btarget", BTarget, 16'h0007);
        chk("dec_jumptarget", jumpTarget, 16'hF967);

        // Extension and link selects
        rf_write(3'd7, 16'hBEEF);
        run(16'h6318, 16'h0010, 2'b10, 1'b0, 1'b1, 1'b0);
        chk("zext_imm", Imm, 16'h0018);
        chk("link_busa", BusA, 16'hBEEF);
        chk("link_dst", dst_addr, 3'd7);
        run(16'h6318, 16'h0010, 2'b10, 1'b0, 1'b0, 1'b1);
        chk("sext_imm", Imm, 16'hFFF8);
        chk("sext_btarget", BTarget, 16'h0008);

        // Handshake: held bundle, dropped enable_id, write to BusA's source during HOLD
        rf_write(3'd2, 16'h0202);
        issue_start(16'h1154, 16'h0100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
`ifdef ID_RF_BYPASS_EN
        hold_a = 16'h5A5A;
        sb_q[sb_q.size()-1].busa = 16'h5A5A;
`else
        hold_a = 16'h1234;
`endif
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5A5A; end
            if (c == 2) begin enable_id = 1'b1; instruction = 16'hFFFF; end
            @(posedge clk); #1;
            wr_en = 1'b0; enable_id = 1'b0;
            chk("hold_id_valid", id_valid, 1'b1);
            chk("hold_opcode", opcode, 4'h1);
            chk("hold_busb", BusB, 16'h0202);
            chk("hold_busa", BusA, hold_a);
        end
        mwrite(3'd5, 16'h5A5A);
        chk("drop_err_set", drop_err, 1'b1);
        ex_ready = 1'b1;
        @(posedge clk); #1;
        chk("accept_idle_busy", busy, 1'b0);
        chk("accept_id_valid", id_valid, 1'b0);

        // Write in the DECODE cycle to the register read on port A
        issue_start(16'hD963, 16'h0004, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 16'hAAAA);
        finish_txn();
`ifdef ID_RF_BYPASS_EN
        chk("decode_bypass_busa", BusA, 16'hAAAA);
`else
        chk("decode_nobypass_busa", BusA, 16'h5A5A);
`endif

        // R0 discard and target wrap
        rf_write(3'd0, 16'hFFFF);
        run(16'h2001, 16'hFFFF, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("r0_busa", BusA, 16'h0000);
        chk("r0_busb", BusB, 16'h0000);
        chk("wrap_btarget", BTarget, 16'h0000);

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            logic rdy;
            for (int k = 0; k < $urandom_range(0, 2); k++)
                rf_write(3'($urandom_range(0, 7)), 16'($urandom));
            rdy = 1'($urandom_range(0, 1));
            issue_start(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), rdy, ($urandom_range(0, 3) == 0),
                        3'($urandom_range(0, 7)), 16'($urandom));
            if (!rdy) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            finish_txn();
        end

        // Asynchronous reset in the middle of HOLD
        issue_start(16'hD963, 16'h1234, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_id_valid", id_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_drop_err", drop_err, 1'b0);
        chk("midrst_opcode", opcode, 4'h0);
        chk("midrst_mode", mode, 1'b0);
        chk("midrst_busa", BusA, 16'h0);
        chk("midrst_busb", BusB, 16'h0);
        chk("midrst_imm", Imm, 16'h0);
        chk("midrst_btarget", BTarget, 16'h0);
        chk("midrst_jumptarget", jumpTarget, 16'h0);
        chk("midrst_dst_addr", dst_addr, 3'd0);
        sb_q.delete();
        for (int k = 0; k < 8; k++) model_rf[k] = 16'h0;
        ex_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int r = 1; r < 8; r++) begin
            w = {4'h3, 3'(r), 3'(r), 3'(r), 3'b000};
            run(w, 16'h0000, 2'b00, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            chk("postrst_reg_a", BusA, 16'h0);
        end

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
